// File: rtl/cicero_cmd_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : AXI_package
// Purpose  : Shared register width, coprocessor command/status encodings and
//            the result code type returned by the command driver.
// Revision : 1.0 - initial release
// ============================================================================
package AXI_package;

  localparam int REG_WIDTH = 32;

  // Commands written to the coprocessor command register
  localparam logic [REG_WIDTH-1:0] CMD_NOP                = 32'd0;
  localparam logic [REG_WIDTH-1:0] CMD_WRITE              = 32'd1;
  localparam logic [REG_WIDTH-1:0] CMD_START              = 32'd2;
  localparam logic [REG_WIDTH-1:0] CMD_RESET              = 32'd3;
  localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED_CLOCK = 32'd4;
  localparam logic [REG_WIDTH-1:0] CMD_RESTART            = 32'd5;

  // Values reported by the coprocessor status register
  localparam logic [REG_WIDTH-1:0] STATUS_IDLE            = 32'd0;
  localparam logic [REG_WIDTH-1:0] STATUS_RUNNING         = 32'd1;
  localparam logic [REG_WIDTH-1:0] STATUS_ACCEPTED        = 32'd2;
  localparam logic [REG_WIDTH-1:0] STATUS_REJECTED        = 32'd3;
  localparam logic [REG_WIDTH-1:0] STATUS_ERROR           = 32'd4;

  typedef enum logic [1:0] {
    RES_ACCEPT  = 2'd0,
    RES_REJECT  = 2'd1,
    RES_ERROR   = 2'd2,
    RES_TIMEOUT = 2'd3
  } driver_result_t;

endpackage
`default_nettype wire

// File: rtl/cicero_cmd_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : cicero_cmd_driver_if
// Purpose  : Job, program-word and result handshakes between a job source
//            (master) and the command driver (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface cicero_cmd_driver_if #(
  parameter int WRITE_ADDR_WIDTH = 10
);
  import AXI_package::*;

  logic                        job_valid;
  logic                        job_ready;
  logic [WRITE_ADDR_WIDTH:0]   job_len;
  logic [REG_WIDTH-1:0]        job_start_cc;
  logic [REG_WIDTH-1:0]        job_end_cc;

  logic                        word_valid;
  logic                        word_ready;
  logic [31:0]                 word_data;

  logic                        res_valid;
  logic                        res_ready;
  driver_result_t              res_code;
  logic [REG_WIDTH-1:0]        res_elapsed;

  modport master (
    output job_valid, job_len, job_start_cc, job_end_cc,
    output word_valid, word_data,
    output res_ready,
    input  job_ready, word_ready, res_valid, res_code, res_elapsed
  );

  modport slave (
    input  job_valid, job_len, job_start_cc, job_end_cc,
    input  word_valid, word_data,
    input  res_ready,
    output job_ready, word_ready, res_valid, res_code, res_elapsed
  );

endinterface
`default_nettype wire

// File: rtl/cicero_cmd_driver_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : cicero_watchdog
// Purpose  : Saturating run-time counter. 'expire' is raised on the cycle the
//            count reaches all-ones and stays raised while saturated.
// Revision : 1.0 - initial release
// ============================================================================
module cicero_watchdog #(
  parameter int WIDTH = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [WIDTH-1:0] C_MAX = '1;

  logic [WIDTH-1:0] r_count;

  // Count enabled cycles, holding at the terminal value instead of wrapping
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != C_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expire = (r_count == C_MAX) || (enable && (r_count == (C_MAX - 1'b1)));

endmodule
`default_nettype wire

// File: rtl/cicero_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module   : cicero_cmd_driver
// Purpose  : Hardware initiator for the coprocessor register interface: loads
//            a program image, starts it, polls completion, reads the elapsed
//            cycle counter, restarts the engine and returns a result record.
// Revision : 1.0 - initial release
// ============================================================================
module cicero_cmd_driver
  import AXI_package::*;
#(
  parameter int WRITE_ADDR_WIDTH = 10,
  parameter int TIMEOUT_WIDTH    = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  cicero_cmd_driver_if.slave    bus,
  output logic [REG_WIDTH-1:0]  cmd_register,
  output logic [REG_WIDTH-1:0]  address_register,
  output logic [REG_WIDTH-1:0]  data_in_register,
  output logic [REG_WIDTH-1:0]  start_cc_pointer_register,
  output logic [REG_WIDTH-1:0]  end_cc_pointer_register,
  input  logic [REG_WIDTH-1:0]  status_register,
  input  logic [REG_WIDTH-1:0]  data_o_register,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_START   = 3'd2,
    S_WAIT    = 3'd3,
    S_READ_CC = 3'd4,
    S_RESTART = 3'd5,
    S_RESULT  = 3'd6
  } state_t;

  localparam int CNT_WIDTH = WRITE_ADDR_WIDTH + 1;

  state_t               r_state, w_state;
  logic [REG_WIDTH-1:0] r_cmd, w_cmd;
  logic [REG_WIDTH-1:0] r_addr, w_addr;
  logic [REG_WIDTH-1:0] r_data, w_data;
  logic [REG_WIDTH-1:0] r_start_cc, w_start_cc;
  logic [REG_WIDTH-1:0] r_end_cc, w_end_cc;
  logic [REG_WIDTH-1:0] r_elapsed, w_elapsed;
  logic [CNT_WIDTH-1:0] r_len, w_len;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt, w_cnt_inc;
  driver_result_t       r_code, w_code;
  logic                 w_wd_clear, w_wd_enable, w_wd_expire;
  logic                 w_job_hs, w_word_hs;

  assign bus.job_ready  = rst && (r_state == S_IDLE) && (status_register == STATUS_IDLE);
  assign bus.word_ready = (r_state == S_LOAD);
  assign bus.res_valid  = (r_state == S_RESULT);
  assign bus.res_code   = r_code;
  assign bus.res_elapsed = r_elapsed;
  assign busy           = (r_state != S_IDLE);

  assign w_job_hs  = bus.job_valid && bus.job_ready;
  assign w_word_hs = bus.word_valid && bus.word_ready;
  assign w_cnt_inc = r_cnt + 1'b1;

  cicero_watchdog #(
    .WIDTH (TIMEOUT_WIDTH)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_wd_clear),
    .enable (w_wd_enable),
    .expire (w_wd_expire)
  );

  // Next-state and next register values; every command is registered
  always_comb begin
    w_state     = r_state;
    w_cmd       = CMD_NOP;
    w_addr      = r_addr;
    w_data      = r_data;
    w_start_cc  = r_start_cc;
    w_end_cc    = r_end_cc;
    w_elapsed   = r_elapsed;
    w_len       = r_len;
    w_cnt       = r_cnt;
    w_code      = r_code;
    w_wd_clear  = 1'b0;
    w_wd_enable = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_job_hs) begin
          w_start_cc = bus.job_start_cc;
          w_end_cc   = bus.job_end_cc;
          w_len      = bus.job_len;
          w_cnt      = '0;
          w_state    = (bus.job_len != '0) ? S_LOAD : S_START;
        end
      end
      S_LOAD: begin
        if (w_word_hs) begin
          w_cmd  = CMD_WRITE;
          w_addr = REG_WIDTH'(r_cnt[WRITE_ADDR_WIDTH-1:0]);
          w_data = bus.word_data;
          w_cnt  = w_cnt_inc;
          if (w_cnt_inc == r_len) w_state = S_START;
        end
      end
      S_START: begin
        // Status is a downstream flop, so START is held until RUNNING is seen
        if (status_register == STATUS_RUNNING) begin
          w_wd_clear = 1'b1;
          w_state    = S_WAIT;
        end else begin
          w_cmd = CMD_START;
        end
      end
      S_WAIT: begin
        w_wd_enable = 1'b1;
        case (status_register)
          STATUS_ACCEPTED: begin
            w_code = RES_ACCEPT; w_cmd = CMD_READ_ELAPSED_CLOCK; w_state = S_READ_CC;
          end
          STATUS_REJECTED: begin
            w_code = RES_REJECT; w_cmd = CMD_READ_ELAPSED_CLOCK; w_state = S_READ_CC;
          end
          STATUS_ERROR: begin
            w_code = RES_ERROR; w_cmd = CMD_READ_ELAPSED_CLOCK; w_state = S_READ_CC;
          end
          default: begin
            // Any other status counts as still running
            if (w_wd_expire) begin
              w_code    = RES_TIMEOUT;
              w_cmd     = CMD_RESET;
              w_elapsed = '0;
              w_state   = S_RESTART;
            end
          end
        endcase
      end
      S_READ_CC: begin
        w_elapsed = data_o_register;
        w_cmd     = CMD_RESTART;
        w_state   = S_RESTART;
      end
      S_RESTART: begin
        // Timeout path already issued a one-cycle RESET; just wait for IDLE
        if (status_register == STATUS_IDLE) begin
          w_state = S_RESULT;
        end else if (r_code != RES_TIMEOUT) begin
          w_cmd = CMD_RESTART;
        end
      end
      S_RESULT: begin
        if (bus.res_ready) w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  // State and output register bank
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cmd      <= CMD_NOP;
      r_addr     <= '0;
      r_data     <= '0;
      r_start_cc <= '0;
      r_end_cc   <= '0;
      r_elapsed  <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_code     <= RES_ACCEPT;
    end else begin
      r_state    <= w_state;
      r_cmd      <= w_cmd;
      r_addr     <= w_addr;
      r_data     <= w_data;
      r_start_cc <= w_start_cc;
      r_end_cc   <= w_end_cc;
      r_elapsed  <= w_elapsed;
      r_len      <= w_len;
      r_cnt      <= w_cnt;
      r_code     <= w_code;
    end
  end

  assign cmd_register              = r_cmd;
  assign address_register          = r_addr;
  assign data_in_register          = r_data;
  assign start_cc_pointer_register = r_start_cc;
  assign end_cc_pointer_register   = r_end_cc;

endmodule
`default_nettype wire

// File: tb/tb_cicero_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_cicero_cmd_driver
// Purpose  : Directed self-checking bench for cicero_cmd_driver with a small
//            behavioural coprocessor register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cicero_cmd_driver;
  import AXI_package::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] cmd_register, address_register, data_in_register;
  logic [31:0] start_cc_pointer_register, end_cc_pointer_register;
  logic [31:0] status_q = STATUS_IDLE;
  logic [31:0] data_o;
  logic        busy;

  int n_pass = 0;
  int n_total = 0;

  cicero_cmd_driver_if #(.WRITE_ADDR_WIDTH(10)) bus ();

  cicero_cmd_driver #(
    .WRITE_ADDR_WIDTH (10),
    .TIMEOUT_WIDTH    (4)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .bus                       (bus),
    .cmd_register              (cmd_register),
    .address_register          (address_register),
    .data_in_register          (data_in_register),
    .start_cc_pointer_register (start_cc_pointer_register),
    .end_cc_pointer_register   (end_cc_pointer_register),
    .status_register           (status_q),
    .data_o_register           (data_o),
    .busy                      (busy)
  );

  always #5 clk = ~clk;

  // Coprocessor model: status flop driven by the command register
  typedef struct { logic [31:0] cmd; logic [31:0] addr; logic [31:0] data; int cyc; } ent_t;
  ent_t        log_q[$];
  ent_t        m_e;
  logic [31:0] m_final = STATUS_ACCEPTED;
  logic [31:0] m_elapsed = 32'd0;
  logic [31:0] prev_cmd = CMD_NOP;
  int          m_run_len = 1;
  int          run_cnt = 0;
  int          cyc = 0;
  bit          m_hang = 1'b0;
  logic [31:0] words [4];

  assign data_o = (cmd_register == CMD_READ_ELAPSED_CLOCK) ? m_elapsed : 32'd0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    prev_cmd <= cmd_register;
    if (cmd_register != CMD_NOP && (cmd_register == CMD_WRITE || cmd_register != prev_cmd)) begin
      m_e.cmd  = cmd_register;
      m_e.addr = address_register;
      m_e.data = data_in_register;
      m_e.cyc  = cyc;
      log_q.push_back(m_e);
    end
    case (cmd_register)
      CMD_START: begin status_q <= STATUS_RUNNING; run_cnt <= 0; end
      CMD_RESTART, CMD_RESET: status_q <= STATUS_IDLE;
      default: begin
        if (status_q == STATUS_RUNNING) begin
          run_cnt <= run_cnt + 1;
          if (!m_hang && (run_cnt + 1 == m_run_len)) status_q <= m_final;
        end
      end
    endcase
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a job, wait for accept, stream its words and wait for the result
  task automatic run_job(input int len, input bit gaps, input logic [31:0] fin,
                         input logic [31:0] el, input int runlen, input bit hang);
    int  t;
    int  i;
    bit  ph;
    bit  hs;
    m_final = fin; m_elapsed = el; m_run_len = runlen; m_hang = hang;
    log_q.delete();
    bus.job_len      = 11'(len);
    bus.job_start_cc = 32'h1000 + 32'(len);
    bus.job_end_cc   = 32'h2000 + 32'(len);
    bus.job_valid    = 1'b1;
    t = 0;
    while (!bus.job_ready && t < 50) begin step(); t++; end
    check("job_ready_wait", bus.job_ready, 1'b1);
    step();
    bus.job_valid = 1'b0;
    check("start_cc_ptr", start_cc_pointer_register, 32'h1000 + 32'(len));
    check("end_cc_ptr", end_cc_pointer_register, 32'h2000 + 32'(len));
    i = 0; ph = 1'b0; t = 0;
    while (i < len && t < 200) begin
      bus.word_valid = gaps ? ph : 1'b1;
      bus.word_data  = words[i];
      hs = bus.word_valid && bus.word_ready;
      step();
      if (hs) i++;
      ph = !ph;
      t++;
    end
    bus.word_valid = 1'b0;
    t = 0;
    while (!bus.res_valid && t < 200) begin step(); t++; end
    check("res_valid_wait", bus.res_valid, 1'b1);
  endtask

  task automatic take_result();
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
  endtask

  initial begin
    bus.job_valid = 1'b0; bus.job_len = '0; bus.job_start_cc = '0; bus.job_end_cc = '0;
    bus.word_valid = 1'b0; bus.word_data = '0; bus.res_ready = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_cmd", cmd_register, CMD_NOP);
    check("rst_addr", address_register, 32'd0);
    check("rst_data", data_in_register, 32'd0);
    check("rst_ptrs", {start_cc_pointer_register, end_cc_pointer_register}, 64'd0);
    check("rst_flags", {busy, bus.job_ready, bus.word_ready, bus.res_valid}, 4'b0000);
    check("rst_res", {bus.res_code, bus.res_elapsed}, 34'd0);
    rst = 1'b1;
    step();
    check("idle_job_ready", bus.job_ready, 1'b1);

    // Load three words back-to-back, accept after 10 running cycles
    words[0] = 32'hA; words[1] = 32'hB; words[2] = 32'hC;
    run_job(3, 1'b0, STATUS_ACCEPTED, 32'd10, 10, 1'b0);
    check("j1_code", bus.res_code, RES_ACCEPT);
    check("j1_elapsed", bus.res_elapsed, 32'd10);
    check("j1_busy", busy, 1'b1);
    take_result();
    check("j1_nlog", log_q.size(), 6);
    check("j1_w0", {log_q[0].cmd, log_q[0].addr, log_q[0].data}, {CMD_WRITE, 32'd0, 32'hA});
    check("j1_w1", {log_q[1].cmd, log_q[1].addr, log_q[1].data}, {CMD_WRITE, 32'd1, 32'hB});
    check("j1_w2", {log_q[2].cmd, log_q[2].addr, log_q[2].data}, {CMD_WRITE, 32'd2, 32'hC});
    check("j1_start", log_q[3].cmd, CMD_START);
    check("j1_spacing", {log_q[1].cyc - log_q[0].cyc, log_q[2].cyc - log_q[1].cyc,
                         log_q[3].cyc - log_q[2].cyc}, {32'd1, 32'd1, 32'd1});
    check("j1_read_restart", {log_q[4].cmd, log_q[5].cmd}, {CMD_READ_ELAPSED_CLOCK, CMD_RESTART});

    // Skip load: no writes, START first; coprocessor rejects
    run_job(0, 1'b0, STATUS_REJECTED, 32'd7, 4, 1'b0);
    check("j2_code", bus.res_code, RES_REJECT);
    check("j2_elapsed", bus.res_elapsed, 32'd7);
    take_result();
    check("j2_first_start", log_q[0].cmd, CMD_START);
    check("j2_nlog", log_q.size(), 3);

    // Word stream with gaps: NOP between writes, addresses 0..3
    words[0] = 32'hD0; words[1] = 32'hD1; words[2] = 32'hD2; words[3] = 32'hD3;
    run_job(4, 1'b1, STATUS_ACCEPTED, 32'd3, 3, 1'b0);
    check("j3_code", bus.res_code, RES_ACCEPT);
    take_result();
    for (int k = 0; k < 4; k++)
      check("j3_write", {log_q[k].cmd, log_q[k].addr, log_q[k].data},
            {CMD_WRITE, 32'(k), words[k]});
    for (int k = 1; k < 4; k++)
      check("j3_gap", log_q[k].cyc - log_q[k-1].cyc, 32'd2);
    check("j3_start", log_q[4].cmd, CMD_START);

    // Error with elapsed 5, RESTART issued, job_ready back once IDLE
    run_job(0, 1'b0, STATUS_ERROR, 32'd5, 5, 1'b0);
    check("j4_code", bus.res_code, RES_ERROR);
    check("j4_elapsed", bus.res_elapsed, 32'd5);
    take_result();
    check("j4_restart", log_q[2].cmd, CMD_RESTART);
    check("j4_job_ready", bus.job_ready, 1'b1);

    // Timeout: START held 2 cycles, 15 WAIT cycles, then RESET
    run_job(0, 1'b0, STATUS_ACCEPTED, 32'd99, 1, 1'b1);
    check("j5_code", bus.res_code, RES_TIMEOUT);
    check("j5_elapsed", bus.res_elapsed, 32'd0);
    take_result();
    check("j5_reset", log_q[1].cmd, CMD_RESET);
    check("j5_reset_delay", log_q[1].cyc - log_q[0].cyc, 32'd17);
    check("j5_nlog", log_q.size(), 2);

    // Reset during word 2 of 4, then a fresh job reloads from address 0
    log_q.delete();
    bus.job_len = 11'd4; bus.job_valid = 1'b1;
    step();
    bus.job_valid = 1'b0;
    check("j6_in_load", bus.word_ready, 1'b1);
    bus.word_valid = 1'b1; bus.word_data = 32'h100;
    step();
    bus.word_data = 32'h200;
    rst = 1'b0;
    step();
    check("j6_rst_cmd", cmd_register, CMD_NOP);
    check("j6_rst_busy", busy, 1'b0);
    bus.word_valid = 1'b0;
    rst = 1'b1;
    step();
    words[0] = 32'h11; words[1] = 32'h22;
    run_job(2, 1'b0, STATUS_ACCEPTED, 32'd4, 4, 1'b0);
    take_result();
    check("j7_w0", {log_q[0].cmd, log_q[0].addr, log_q[0].data}, {CMD_WRITE, 32'd0, 32'h11});
    check("j7_w1", {log_q[1].cmd, log_q[1].addr, log_q[1].data}, {CMD_WRITE, 32'd1, 32'h22});
    check("j7_elapsed", bus.res_elapsed, 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish before 200000");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
